hazard_ctrl_unit: RTL and testbench

//  Drives the enable/flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It sits between decode, execute
//  and the data-memory port and turns hazards into stall/bubble/flush commands. Handles load-use stalls, EX-resolved

---
 rtl/hazard_ctrl_unit_pkg.sv | 74 +++++++
 rtl/hazard_ctrl_unit_hz_sat_counter.sv | 29 ++
 rtl/hazard_ctrl_unit.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared types and control constants for the hazard controller
//
// Purpose : stall-cause / FSM state encodings, the packed pipeline-control bundle
//           driven by the hazard controller, and the load-use detect helper.
// Ports   : none (package).
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    STALL_NONE     = 2'd0,
    STALL_LOAD_USE = 2'd1,
    STALL_MEM      = 2'd2,
    STALL_REDIRECT = 2'd3
  } stall_cause_t;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERR      = 2'd2
  } hz_state_t;

  // One cycle's worth of pipeline-register controls.
  typedef struct packed {
    logic         pc_en;
    logic         if_id_en;
    logic         if_id_flush;
    logic         id_ex_en;
    logic         id_ex_flush;
    logic         ex_mem_en;
    logic         mem_wb_bubble;
    stall_cause_t cause;
  } hz_ctrl_t;

  // Pipeline held in reset: nothing moves, nothing is flushed.
  localparam hz_ctrl_t HZ_CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_bubble: 1'b0, cause: STALL_NONE};

  // Normal flow.
  localparam hz_ctrl_t HZ_CTRL_NONE = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0, cause: STALL_NONE};

  // Whole pipe frozen behind the data memory; MEM/WB sees a bubble so a
  // stalled access is never written back twice.
  localparam hz_ctrl_t HZ_CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_bubble: 1'b1, cause: STALL_MEM};

  // Wrong-path instructions in IF/ID and ID/EX are squashed; the pipe keeps moving.
  localparam hz_ctrl_t HZ_CTRL_REDIRECT = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0, cause: STALL_REDIRECT};

  // Hold PC and IF/ID, inject a bubble into EX while the load moves on to MEM.
  // id_ex_en stays high; the flush wins so ID/EX captures a bubble.
  localparam hz_ctrl_t HZ_CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0, cause: STALL_LOAD_USE};

  // True when the ID instruction needs a value the EX load has not produced yet.
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd_idx,
    input logic       uses_rs1,
    input logic [4:0] rs1_idx,
    input logic       uses_rs2,
    input logic [4:0] rs2_idx
  );
    return mem_read && (rd_idx != 5'd0) &&
           ((uses_rs1 && (rs1_idx == rd_idx)) || (uses_rs2 && (rs2_idx == rd_idx)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_hz_sat_counter.sv
// rtl/hazard_ctrl_unit_hz_sat_counter.sv - saturating event counter
//
// Purpose : counts cycles in which i_inc is high, sticking at all-ones.
// Ports   : i_clk     clock, rising edge
//           i_reset   asynchronous active-high reset, clears the count
//           i_inc     count this cycle
//           o_count   current count (CNT_W bits)
module hz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller (load-use, redirect, dmem stall + watchdog)
//
// Purpose : turns hazards into enable/flush commands for the PC, IF/ID, ID/EX,
//           EX/MEM and MEM/WB pipeline registers. All controls are combinational
//           from the FSM state and the current inputs.
// Config  : HAZARD_PERF_CNT_EN - when defined, builds three saturating
//           performance counters; otherwise o_perf_* are tied to zero.
// Ports   : i_clk, i_reset              clock / asynchronous active-high reset
//           i_id_rs1_idx/i_id_rs2_idx   source registers of the ID instruction
//           i_id_uses_rs1/i_id_uses_rs2 ID instruction actually reads that source
//           i_ex_rd_idx, i_ex_mem_read  destination / is-load of the EX instruction
//           i_ex_redirect               EX resolved a taken control transfer
//           i_dmem_req, i_dmem_ack      MEM access pending / completing this cycle
//           o_pc_en .. o_mem_wb_bubble  pipeline-register controls
//           o_stall_cause               stall_cause_t of this cycle
//           o_mem_timeout_err           sticky dmem watchdog error
//           o_perf_load_use/mem_stall/redirect  performance counters
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_idx,
  input  logic [4:0]       i_id_rs2_idx,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd_idx,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_redirect,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_bubble,
  output logic [1:0]       o_stall_cause,
  output logic             o_mem_timeout_err,
  output logic [CNT_W-1:0] o_perf_load_use,
  output logic [CNT_W-1:0] o_perf_mem_stall,
  output logic [CNT_W-1:0] o_perf_redirect
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout_err;
  logic              w_mem_stall;
  logic              w_load_use;
  hz_ctrl_t          w_ctrl;

  // ERR has already given up on the access, so a still-high request there is
  // not a stall in its own right (it does not count and does not re-arm).
  assign w_mem_stall = i_dmem_req && !i_dmem_ack && (r_state != HZ_ERR);

  assign w_load_use = load_use_hit(i_ex_mem_read, i_ex_rd_idx,
                                   i_id_uses_rs1, i_id_rs1_idx,
                                   i_id_uses_rs2, i_id_rs2_idx);

  // State register, watchdog counter and sticky error.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= HZ_RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_mem_stall) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if ((w_state_nxt == HZ_ERR) && (r_state != HZ_ERR)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Next-state logic. A request acked in the same RUN cycle never leaves RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = HZ_MEM_WAIT;
        end
      end
      HZ_MEM_WAIT: begin
        if (!i_dmem_req || i_dmem_ack) begin
          w_state_nxt = HZ_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          // This is the MEM_TIMEOUT-th consecutive stall cycle.
          w_state_nxt = HZ_ERR;
        end
      end
      HZ_ERR: begin
        w_state_nxt = HZ_ERR;
      end
      default: begin
        w_state_nxt = HZ_RUN;
      end
    endcase
  end

  // Output priority: reset > ERR > mem stall > redirect > load-use > none.
  // A redirect or load-use that arrives during a freeze is simply held by the
  // upstream stages and takes effect in the first unfrozen cycle (the ack
  // cycle), so no flush is ever issued while the pipe is frozen.
  always_comb begin
    w_ctrl = HZ_CTRL_NONE;
    if (i_reset) begin
      w_ctrl = HZ_CTRL_RESET;
    end else if ((r_state == HZ_ERR) || w_mem_stall) begin
      w_ctrl = HZ_CTRL_FREEZE;
    end else if (i_ex_redirect) begin
      // Load-use is irrelevant here: the consumer in ID is on the wrong path.
      w_ctrl = HZ_CTRL_REDIRECT;
    end else if (w_load_use) begin
      w_ctrl = HZ_CTRL_LOAD_USE;
    end
  end

  assign o_pc_en           = w_ctrl.pc_en;
  assign o_if_id_en        = w_ctrl.if_id_en;
  assign o_if_id_flush     = w_ctrl.if_id_flush;
  assign o_id_ex_en        = w_ctrl.id_ex_en;
  assign o_id_ex_flush     = w_ctrl.id_ex_flush;
  assign o_ex_mem_en       = w_ctrl.ex_mem_en;
  assign o_mem_wb_bubble   = w_ctrl.mem_wb_bubble;
  assign o_stall_cause     = w_ctrl.cause;
  assign o_mem_timeout_err = r_timeout_err;

`ifdef HAZARD_PERF_CNT_EN
  logic w_inc_load_use;
  logic w_inc_redirect;

  assign w_inc_load_use = !i_reset && (w_ctrl.cause == STALL_LOAD_USE);
  assign w_inc_redirect = !i_reset && (w_ctrl.cause == STALL_REDIRECT);

  hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_inc_load_use),
    .o_count (o_perf_load_use)
  );

  // Only genuine dmem stall cycles count; time parked in ERR does not.
  hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_mem_stall (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_mem_stall),
    .o_count (o_perf_mem_stall)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_redirect (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_inc_redirect),
    .o_count (o_perf_redirect)
  );
`else
  assign o_perf_load_use  = '0;
  assign o_perf_mem_stall = '0;
  assign o_perf_redirect  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  localparam int CW = 4;

  // Expected control word: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //                         ex_mem_en, mem_wb_bubble, stall_cause[1:0], timeout_err}
  localparam logic [9:0] C_RST  = 10'b000000_0_00_0;
  localparam logic [9:0] C_NONE = 10'b110101_0_00_0;
  localparam logic [9:0] C_LU   = 10'b000111_0_01_0;
  localparam logic [9:0] C_RD   = 10'b111111_0_11_0;
  localparam logic [9:0] C_MEM  = 10'b000000_1_10_0;
  localparam logic [9:0] C_ERR  = 10'b000000_1_10_1;

  typedef struct {
    string          name;
    logic [9:0]     ctrl;
    logic [CW-1:0]  lu;
    logic [CW-1:0]  ms;
    logic [CW-1:0]  rd;
  } exp_t;

  exp_t q[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic          u1 = 1'b0, u2 = 1'b0, mr = 1'b0, redir = 1'b0, req = 1'b0, ack = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble, err;
  logic [1:0]    cause;
  logic [CW-1:0] p_lu, p_ms, p_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MEM_TIMEOUT(8), .CNT_W(CW)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_id_rs1_idx      (rs1),
    .i_id_rs2_idx      (rs2),
    .i_id_uses_rs1     (u1),
    .i_id_uses_rs2     (u2),
    .i_ex_rd_idx       (rd),
    .i_ex_mem_read     (mr),
    .i_ex_redirect     (redir),
    .i_dmem_req        (req),
    .i_dmem_ack        (ack),
    .o_pc_en           (pc_en),
    .o_if_id_en        (if_id_en),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_en        (id_ex_en),
    .o_id_ex_flush     (id_ex_flush),
    .o_ex_mem_en       (ex_mem_en),
    .o_mem_wb_bubble   (bubble),
    .o_stall_cause     (cause),
    .o_mem_timeout_err (err),
    .o_perf_load_use   (p_lu),
    .o_perf_mem_stall  (p_ms),
    .o_perf_redirect   (p_rd)
  );

  // Expected counter value: saturating at CW bits when counters are built, else 0.
  function automatic logic [CW-1:0] pv(input int x);
`ifdef HAZARD_PERF_CNT_EN
    return (x > (1 << CW) - 1) ? {CW{1'b1}} : CW'(x);
`else
    return '0;
`endif
  endfunction

  // Apply one cycle of inputs and queue what the DUT must show during it.
  task automatic step(input string nm, input logic r,
                      input int a1, input logic b1, input int a2, input logic b2,
                      input int d, input logic m, input logic rdr,
                      input logic rq, input logic ak,
                      input logic [9:0] ec, input int elu, input int ems, input int erd);
    exp_t e;
    rst = r; rs1 = 5'(a1); u1 = b1; rs2 = 5'(a2); u2 = b2; rd = 5'(d);
    mr = m; redir = rdr; req = rq; ack = ak;
    e.name = nm; e.ctrl = ec; e.lu = pv(elu); e.ms = pv(ems); e.rd = pv(erd);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so every mid-cycle sample is a response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] got;
      e = q.pop_front();
      got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble, cause, err};
      checks++;
      if (got !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl: got %b required %b", e.name, got, e.ctrl);
      end
      checks++;
      if ({p_lu, p_ms, p_rd} !== {e.lu, e.ms, e.rd}) begin
        errors++;
        $display("FAIL %s perf lu/ms/rd: got %0d/%0d/%0d required %0d/%0d/%0d",
                 e.name, p_lu, p_ms, p_rd, e.lu, e.ms, e.rd);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    //    name        rst rs1 u1 rs2 u2 rd mr rdr rq ak  ctrl    lu ms rd
    step("reset",     1,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_RST,  0, 0, 0);
    step("idle",      0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 0, 0, 0);
    // load-use
    step("lu_rs2",    0,  1, 1,  5, 1,  5, 1, 0,  0, 0,  C_LU,   0, 0, 0);
    step("lu_after",  0,  1, 1,  5, 1,  5, 0, 0,  0, 0,  C_NONE, 1, 0, 0);
    step("lu_x0",     0,  0, 1,  0, 1,  0, 1, 0,  0, 0,  C_NONE, 1, 0, 0);
    step("lu_rs1",    0,  7, 1,  3, 0,  7, 1, 0,  0, 0,  C_LU,   1, 0, 0);
    step("lu_nouse",  0,  7, 0,  3, 0,  7, 1, 0,  0, 0,  C_NONE, 2, 0, 0);
    step("lu_noload", 0,  7, 1,  7, 1,  7, 0, 0,  0, 0,  C_NONE, 2, 0, 0);
    // redirect overrides load-use
    step("redir_lu",  0,  1, 1,  5, 1,  5, 1, 1,  0, 0,  C_RD,   2, 0, 0);
    step("redir_aft", 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 2, 0, 1);
    // 4-cycle dmem stall, ack on fifth
    for (int i = 0; i < 4; i++)
      step("mem4",    0,  0, 0,  0, 0,  0, 0, 0,  1, 0,  C_MEM,  2, i, 1);
    step("mem4_ack",  0,  0, 0,  0, 0,  0, 0, 0,  1, 1,  C_NONE, 2, 4, 1);
    step("mem4_aft",  0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 2, 4, 1);
    step("req_ack",   0,  0, 0,  0, 0,  0, 0, 0,  1, 1,  C_NONE, 2, 4, 1);
    // redirect held across a 3-cycle stall
    for (int i = 0; i < 3; i++)
      step("mem_redir", 0, 0, 0,  0, 0,  0, 0, 1,  1, 0,  C_MEM,  2, 4 + i, 1);
    step("redir_ack", 0,  0, 0,  0, 0,  0, 0, 1,  1, 1,  C_RD,   2, 7, 1);
    step("redir_aft2",0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 2, 7, 2);
    // request withdrawn without ack
    step("mem_drop",  0,  0, 0,  0, 0,  0, 0, 0,  1, 0,  C_MEM,  2, 7, 2);
    step("req_drop",  0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 2, 8, 2);
    // load-use held across a stall
    step("mem_lu",    0,  0, 0,  6, 1,  6, 1, 0,  1, 0,  C_MEM,  2, 8, 2);
    step("lu_ack",    0,  0, 0,  6, 1,  6, 1, 0,  1, 1,  C_LU,   2, 9, 2);
    step("lu_ack_aft",0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 3, 9, 2);
    // watchdog: 8 stall cycles then ERR (mem counter saturates at 15)
    for (int i = 0; i < 8; i++)
      step("timeout",  0, 0, 0,  0, 0,  0, 0, 0,  1, 0,  C_MEM,  3, 9 + i, 2);
    step("err",       0,  0, 0,  0, 0,  0, 0, 0,  1, 0,  C_ERR,  3, 17, 2);
    step("err_idle",  0,  1, 1,  5, 1,  5, 1, 1,  0, 0,  C_ERR,  3, 17, 2);
    step("err_ack",   0,  0, 0,  0, 0,  0, 0, 0,  1, 1,  C_ERR,  3, 17, 2);
    // asynchronous reset with no clock edge in between
    step("rst_async", 1,  0, 0,  0, 0,  0, 0, 0,  1, 0,  C_RST,  0, 0, 0);
    step("rst_aft",   0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 0, 0, 0);
    // 7 stall cycles is one short of the timeout
    for (int i = 0; i < 7; i++)
      step("mem7",    0,  0, 0,  0, 0,  0, 0, 0,  1, 0,  C_MEM,  0, i, 0);
    step("mem7_ack",  0,  0, 0,  0, 0,  0, 0, 0,  1, 1,  C_NONE, 0, 7, 0);
    step("mem7_aft",  0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  C_NONE, 0, 7, 0);
    step("mem_again", 0,  0, 0,  0, 0,  0, 0, 0,  1, 0,  C_MEM,  0, 7, 0);
    step("again_ack", 0,  0, 0,  0, 0,  0, 0, 0,  1, 1,  C_NONE, 0, 8, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
